// File: rtl/mpt_pkg.sv
// Shared MPT walker types and constants used by the forwarding-buffer flush controller.
package mpt_pkg;

   localparam int FWD_TAG_WIDTH = 34;

   // Pattern the forwarding buffer writes into an entry to mark it invalid.
   localparam logic [FWD_TAG_WIDTH-1:0] FWD_INVALID_TAG = '1;

   typedef enum logic [2:0] {
      FWD_FLUSH_IDLE  = 3'd0,
      FWD_FLUSH_DRAIN = 3'd1,
      FWD_FLUSH_SWEEP = 3'd2,
      FWD_FLUSH_CLEAR = 3'd3,
      FWD_FLUSH_DONE  = 3'd4
   } fwd_flush_state_e;

endpackage

// File: rtl/fwd_buffer_flush_ctrl_inflight_counter.sv
// Saturating up/down count of walks between the parsing input and the memory-stage update.
module inflight_counter #(
   parameter  int MAX = 4,
   localparam int W   = $clog2(MAX + 1)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] count_o,
   output logic         zero_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_ni) begin
         count_q <= '0;
      end else if (inc_i && !dec_i) begin
         if (count_q != W'(MAX)) count_q <= count_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         if (count_q != '0) count_q <= count_q - 1'b1;
      end
   end

   // Overflow and underflow are upstream protocol errors; the count holds instead of wrapping.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(inc_i && !dec_i && count_q == W'(MAX)));
         assert (!(dec_i && !inc_i && count_q == '0));
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/fwd_buffer_flush_ctrl.sv
// Forwarding-buffer flush controller: stall and drain in-flight walks, then invalidate
// every entry or sweep the buffer for entries tagged with the fenced MPTE pointer.
module fwd_buffer_flush_ctrl
   import mpt_pkg::*;
#(
   parameter  int FORWARDING_BUFFER_DEPTH = 32,
   parameter  int MPTE_PTR_WIDTH          = 34,
   parameter  int MAX_INFLIGHT            = 4,
   localparam int IDX_W                   = $clog2(FORWARDING_BUFFER_DEPTH),
   localparam int CNT_W                   = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_req_i,
   input  logic                      flush_all_i,
   input  logic [MPTE_PTR_WIDTH-1:0] flush_tag_i,
   output logic                      flush_ack_o,
   output logic                      flush_done_o,
   output logic                      stall_o,
   input  logic                      inflight_inc_i,
   input  logic                      inflight_dec_i,
   output logic [IDX_W-1:0]          scan_idx_o,
   input  logic [MPTE_PTR_WIDTH-1:0] scan_tag_i,
   output logic                      inv_valid_o,
   output logic [IDX_W-1:0]          inv_idx_o,
   output logic                      inv_all_o,
   output logic                      victim_rst_o
);

   fwd_flush_state_e          state_q, state_d;
   logic                      flush_all_q;
   logic [MPTE_PTR_WIDTH-1:0] flush_tag_q;
   logic [IDX_W-1:0]          scan_q;
   logic [CNT_W-1:0]          inflight_cnt;
   logic                      inflight_zero;
   logic                      drain_done;
   logic                      scan_last;

   inflight_counter #(.MAX(MAX_INFLIGHT)) u_inflight (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (inflight_inc_i),
      .dec_i   (inflight_dec_i),
      .count_o (inflight_cnt),
      .zero_o  (inflight_zero)
   );

   // Leave DRAIN once the count is zero after this edge; a walk entering this cycle keeps us here.
   assign drain_done = !inflight_inc_i &&
                       (inflight_zero || (inflight_cnt == CNT_W'(1) && inflight_dec_i));
   assign scan_last  = (scan_q == IDX_W'(FORWARDING_BUFFER_DEPTH - 1));

   always_comb begin
      // NOTE: state_d gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      case (state_q)
         FWD_FLUSH_IDLE:  if (flush_req_i) state_d = FWD_FLUSH_DRAIN;
         FWD_FLUSH_DRAIN: if (drain_done)  state_d = flush_all_q ? FWD_FLUSH_CLEAR : FWD_FLUSH_SWEEP;
         FWD_FLUSH_SWEEP: if (scan_last)   state_d = FWD_FLUSH_DONE;
         FWD_FLUSH_CLEAR: state_d = FWD_FLUSH_DONE;
         FWD_FLUSH_DONE:  state_d = FWD_FLUSH_IDLE;
         default:         state_d = FWD_FLUSH_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= FWD_FLUSH_IDLE;
         flush_all_q <= 1'b0;
         flush_tag_q <= '0;
         scan_q      <= '0;
      end else begin
         state_q <= state_d;
         if (flush_ack_o) begin
            flush_all_q <= flush_all_i;
            flush_tag_q <= flush_tag_i;
         end
         // Power-of-two depth: the last increment wraps the index back to 0 for the next sweep.
         if (state_q == FWD_FLUSH_SWEEP) scan_q <= scan_q + 1'b1;
      end
   end

   assign flush_ack_o  = (state_q == FWD_FLUSH_IDLE) && flush_req_i;
   assign stall_o      = (state_q != FWD_FLUSH_IDLE);
   assign flush_done_o = (state_q == FWD_FLUSH_DONE);
   assign scan_idx_o   = scan_q;
   assign inv_idx_o    = scan_q;
   assign inv_valid_o  = (state_q == FWD_FLUSH_SWEEP) && (scan_tag_i == flush_tag_q);
   assign inv_all_o    = (state_q == FWD_FLUSH_CLEAR);
   assign victim_rst_o = (state_q == FWD_FLUSH_CLEAR);

endmodule

// File: tb/tb_fwd_buffer_flush_ctrl.sv
// Self-checking bench for fwd_buffer_flush_ctrl: transaction-level model plus buffer model,
// directed scenarios with literal timing expectations, then randomized traffic.
module tb_fwd_buffer_flush_ctrl;
   import mpt_pkg::*;

   localparam int DEPTH = 32;
   localparam int TW    = 34;
   localparam int MAXI  = 4;
   localparam int IW    = 5;
   localparam logic [TW-1:0] ONES = FWD_INVALID_TAG;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b1;
   logic          flush_req_i = 1'b0;
   logic          flush_all_i = 1'b0;
   logic [TW-1:0] flush_tag_i = '0;
   logic          inflight_inc_i = 1'b0;
   logic          inflight_dec_i = 1'b0;
   logic          flush_ack_o, flush_done_o, stall_o;
   logic [IW-1:0] scan_idx_o, inv_idx_o;
   logic [TW-1:0] scan_tag_i;
   logic          inv_valid_o, inv_all_o, victim_rst_o;

   // Forwarding-buffer tags, read combinationally at the scan index.
   logic [TW-1:0] mem [DEPTH];
   assign scan_tag_i = mem[scan_idx_o];

   fwd_buffer_flush_ctrl #(
      .FORWARDING_BUFFER_DEPTH(DEPTH), .MPTE_PTR_WIDTH(TW), .MAX_INFLIGHT(MAXI)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .flush_req_i(flush_req_i), .flush_all_i(flush_all_i), .flush_tag_i(flush_tag_i),
      .flush_ack_o(flush_ack_o), .flush_done_o(flush_done_o), .stall_o(stall_o),
      .inflight_inc_i(inflight_inc_i), .inflight_dec_i(inflight_dec_i),
      .scan_idx_o(scan_idx_o), .scan_tag_i(scan_tag_i),
      .inv_valid_o(inv_valid_o), .inv_idx_o(inv_idx_o),
      .inv_all_o(inv_all_o), .victim_rst_o(victim_rst_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Model: a flush is "draining" until the walk count empties, then runs m_k cycles of work.
   bit            m_active = 1'b0;
   bit            m_drain  = 1'b0;
   bit            m_all    = 1'b0;
   logic [TW-1:0] m_tag    = '0;
   int            m_k      = 0;
   int            m_count  = 0;
   int            m_nxt;
   int            cyc      = 0;

   always @(posedge clk) cyc++;

   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         m_active = 1'b0;
         m_drain  = 1'b0;
         m_k      = 0;
         m_count  = 0;
      end else begin
         if (inv_all_o) for (int i = 0; i < DEPTH; i++) mem[i] = ONES;
         else if (inv_valid_o) mem[inv_idx_o] = ONES;
         m_nxt = m_count;
         if (inflight_inc_i && !inflight_dec_i && m_count < MAXI) m_nxt = m_count + 1;
         if (inflight_dec_i && !inflight_inc_i && m_count > 0)    m_nxt = m_count - 1;
         if (!m_active) begin
            if (flush_req_i) begin
               m_active = 1'b1;
               m_drain  = 1'b1;
               m_all    = flush_all_i;
               m_tag    = flush_tag_i;
            end
         end else if (m_drain) begin
            if (!inflight_inc_i && m_nxt == 0) begin
               m_drain = 1'b0;
               m_k     = 0;
            end
         end else if (m_k == (m_all ? 1 : DEPTH)) begin
            m_active = 1'b0;
         end else begin
            m_k++;
         end
         m_count = m_nxt;
      end
   end

   // Per-cycle comparison plus event log used by the directed timing checks.
   bit            e_post;
   bit            e_scan;
   logic [IW-1:0] e_idx;
   logic [15:0]   e_vec, a_vec;
   int            last_done = -100;
   int            last_clear = -100;
   int            done_cnt = 0;
   int            victim_cnt = 0;
   int            hits[$];

   always @(negedge clk) begin
      e_post = m_active && !m_drain;
      e_scan = e_post && !m_all && m_k < DEPTH;
      e_idx  = e_scan ? IW'(m_k) : '0;
      e_vec  = {!m_active && flush_req_i,
                e_post && m_k == (m_all ? 1 : DEPTH),
                m_active,
                e_scan && mem[e_idx] == m_tag,
                e_post && m_all && m_k == 0,
                e_post && m_all && m_k == 0,
                e_idx, e_idx};
      a_vec  = {flush_ack_o, flush_done_o, stall_o, inv_valid_o, inv_all_o, victim_rst_o,
                scan_idx_o, inv_idx_o};
      check($sformatf("outputs cycle %0d", cyc), 32'(a_vec), 32'(e_vec));
      if (flush_done_o) begin
         done_cnt++;
         last_done = cyc;
      end
      if (inv_all_o)    last_clear = cyc;
      if (victim_rst_o) victim_cnt++;
      if (inv_valid_o)  hits.push_back(int'(inv_idx_o));
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [TW-1:0] rand_tag();
      return {2'b01, 32'($urandom())};
   endfunction

   int  ack_c;
   int  d0;
   int  acks[$];
   bit  found;
   bit  will_ack;

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = rand_tag();
      #1 rst_ni = 1'b0;
      #1 flush_req_i = 1'b1;
      #1;
      check("reset ack follows req", 32'(flush_ack_o), 32'd1);
      check("reset outputs idle", 32'({flush_done_o, stall_o, inv_valid_o, inv_all_o,
                                        victim_rst_o, scan_idx_o, inv_idx_o}), 32'd0);
      flush_req_i = 1'b0;
      step(2);
      rst_ni = 1'b1;
      step(2);

      // Global flush with nothing in flight.
      flush_req_i = 1'b1; flush_all_i = 1'b1; flush_tag_i = '0; ack_c = cyc;
      step(1);
      flush_req_i = 1'b0;
      step(4);
      check("global done latency", 32'(last_done - ack_c), 32'd3);
      check("global clear latency", 32'(last_clear - ack_c), 32'd2);

      // Selective flush, matches at entries 3 and 17.
      mem[3] = 34'h100; mem[17] = 34'h100;
      hits.delete(); victim_cnt = 0;
      flush_req_i = 1'b1; flush_all_i = 1'b0; flush_tag_i = 34'h100; ack_c = cyc;
      step(1);
      flush_req_i = 1'b0;
      step(36);
      check("selective done latency", 32'(last_done - ack_c), 32'd34);
      check("selective hit count", 32'(hits.size()), 32'd2);
      check("selective hit 0", 32'(hits.size() > 0 ? hits[0] : 999), 32'd3);
      check("selective hit 1", 32'(hits.size() > 1 ? hits[1] : 999), 32'd17);
      check("selective victim untouched", 32'(victim_cnt), 32'd0);
      check("entry 3 invalidated", 32'(mem[3] == ONES), 32'd1);
      check("entry 17 invalidated", 32'(mem[17] == ONES), 32'd1);

      // Drain: count 2, inc in the ack cycle, retirements at cycles 4, 6, 9.
      inflight_inc_i = 1'b1;
      step(2);
      inflight_inc_i = 1'b0;
      step(1);
      flush_req_i = 1'b1; flush_all_i = 1'b1; inflight_inc_i = 1'b1; ack_c = cyc;
      step(1);
      flush_req_i = 1'b0; inflight_inc_i = 1'b0;
      for (int i = 1; i <= 13; i++) begin
         inflight_dec_i = (i == 4 || i == 6 || i == 9);
         step(1);
      end
      inflight_dec_i = 1'b0;
      check("drain done latency", 32'(last_done - ack_c), 32'd11);
      check("drain clear latency", 32'(last_clear - ack_c), 32'd10);

      // Simultaneous inc & dec at count 1 holds DRAIN; a lone dec then releases it.
      inflight_inc_i = 1'b1;
      step(1);
      inflight_inc_i = 1'b0;
      flush_req_i = 1'b1; flush_all_i = 1'b1; ack_c = cyc;
      step(1);
      flush_req_i = 1'b0; inflight_inc_i = 1'b1; inflight_dec_i = 1'b1;
      step(1);
      inflight_inc_i = 1'b0;
      step(1);
      inflight_dec_i = 1'b0;
      step(4);
      check("inc+dec done latency", 32'(last_done - ack_c), 32'd4);
      check("inc+dec clear latency", 32'(last_clear - ack_c), 32'd3);

      // Reset in the middle of a sweep.
      d0 = done_cnt;
      flush_req_i = 1'b1; flush_all_i = 1'b0; flush_tag_i = 34'h2AB;
      step(1);
      flush_req_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (stall_o && scan_idx_o == IW'(10)) found = 1'b1;
      end
      check("sweep reached index 10", 32'(found), 32'd1);
      #1 rst_ni = 1'b0;
      #1;
      check("outputs cleared by reset", 32'({flush_ack_o, flush_done_o, stall_o, inv_valid_o,
                                              inv_all_o, victim_rst_o, scan_idx_o, inv_idx_o}),
            32'd0);
      step(2);
      rst_ni = 1'b1;
      step(3);
      check("no done after abandoned flush", 32'(done_cnt - d0), 32'd0);
      flush_req_i = 1'b1; flush_all_i = 1'b0; flush_tag_i = 34'h2AB;
      step(1);
      flush_req_i = 1'b0;
      step(1);
      @(negedge clk);
      check("restarted sweep at index 0", 32'({stall_o, scan_idx_o}), 32'({1'b1, 5'd0}));
      step(40);

      // Request held through a flush: second ack only after DONE; tag 0xFFF never matches.
      hits.delete(); acks.delete();
      flush_req_i = 1'b1; flush_all_i = 1'b0; flush_tag_i = 34'hFFF;
      for (int i = 0; i < 100 && acks.size() < 2; i++) begin
         @(negedge clk);
         if (flush_ack_o) acks.push_back(cyc);
      end
      @(posedge clk);
      #1 flush_req_i = 1'b0;
      step(40);
      check("held request ack count", 32'(acks.size()), 32'd2);
      check("second ack spacing", 32'(acks.size() == 2 ? acks[1] - acks[0] : -1), 32'd35);
      check("no hits for absent tag", 32'(hits.size()), 32'd0);

      // Randomized traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         if (!flush_req_i && $urandom_range(0, 9) == 0) begin
            flush_req_i = 1'b1;
            flush_all_i = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
               0:       flush_tag_i = mem[$urandom_range(0, DEPTH - 1)];
               1:       flush_tag_i = 34'h200;
               default: flush_tag_i = 34'h300;
            endcase
         end
         inflight_inc_i = !m_active && m_count < MAXI && $urandom_range(0, 2) == 0;
         inflight_dec_i = m_count > 0 && $urandom_range(0, 3) == 0;
         if (!m_active && $urandom_range(0, 3) == 0)
            mem[$urandom_range(0, DEPTH - 1)] = $urandom_range(0, 1) ? 34'h200 : 34'h300;
         will_ack = flush_req_i && !m_active;
         step(1);
         if (will_ack) flush_req_i = 1'b0;
      end
      flush_req_i = 1'b0; inflight_inc_i = 1'b0; inflight_dec_i = 1'b0;
      step(60);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fwd_buffer_flush_ctrl.md
# fwd_buffer_flush_ctrl

Flush controller for the walking-stage forwarding buffer. On an MPT fence it stalls the walking-stage input and waits for in-flight walks to drain. It then invalidates either every buffer entry (global flush) or only the entries whose tag matches a given MPTE pointer (selective flush), and signals completion. It sits beside the forwarding buffer: it gates the parsing-stage ready path and drives the buffer's invalidation port.

## Interface
Parameters:
- FORWARDING_BUFFER_DEPTH, 32, number of buffer entries; power of two, ≥2
- MPTE_PTR_WIDTH, 34, width of an MPTE pointer/tag
- MAX_INFLIGHT, 4, maximum walks in flight between parsing input and memory-stage update

Ports:
- clk_i  in  1  clock; the only clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_req_i  in  1  flush request; held until acknowledged
- flush_all_i  in  1  qualifies flush_req_i: 1 = global, 0 = selective
- flush_tag_i  in  MPTE_PTR_WIDTH  tag to invalidate (selective only)
- flush_ack_o  out  1  request accepted this cycle
- flush_done_o  out  1  one-cycle completion pulse
- stall_o  out  1  forces parsing_slave_stage_ready low while high
- inflight_inc_i  in  1  a walk entered (parsing valid & ready)
- inflight_dec_i  in  1  a walk retired (mem_slave_stage valid)
- scan_idx_o  out  $clog2(FORWARDING_BUFFER_DEPTH)  entry index being read
- scan_tag_i  in  MPTE_PTR_WIDTH  mpte_tag of entry scan_idx_o, same-cycle read
- inv_valid_o  out  1  write invalid pattern to entry inv_idx_o
- inv_idx_o  out  $clog2(FORWARDING_BUFFER_DEPTH)  entry to invalidate
- inv_all_o  out  1  invalidate all entries this cycle
- victim_rst_o  out  1  reset the buffer's next-victim pointer to 0

## Operation
- States: IDLE, DRAIN, SWEEP, CLEAR, DONE.
- IDLE:
  - flush_ack_o = flush_req_i.
  - On ack: capture flush_all_i/flush_tag_i and go to DRAIN.
- DRAIN:
  - Stay while inflight count ≠ 0 or inflight_inc_i = 1.
  - Otherwise go to CLEAR (global) or SWEEP (selective).
- SWEEP:
  - scan_idx_o = scan counter, starting at 0.
  - inv_valid_o = (scan_tag_i == captured tag); inv_idx_o = scan_idx_o.
  - Counter increments each cycle.
  - At index DEPTH-1: counter wraps to 0 and the FSM goes to DONE.
  - The invalidation of the last entry is still performed that cycle.
- CLEAR: inv_all_o = 1 and victim_rst_o = 1 for one cycle, then DONE.
- DONE: flush_done_o = 1 for one cycle, then IDLE.
- A new request is acknowledged only in IDLE, so back-to-back flushes need at least one IDLE cycle between them.
- stall_o = (state ≠ IDLE). A transaction accepted in the ack cycle is counted and drained.
- Inflight counter:
  - Width $clog2(MAX_INFLIGHT+1).
  - inc & dec in the same cycle: no change.
  - inc at MAX_INFLIGHT saturates and raises a simulation assertion.
  - dec at 0 is ignored and raises an assertion.
- Selective flush never touches the victim pointer. An invalidated entry receives the all-ones pattern (the invalid tag).

## Timing
- Reset (asynchronous, any state): state IDLE, inflight count 0, scan counter 0, captured tag 0. All outputs 0 except flush_ack_o, which follows flush_req_i.
- Reset mid-flush abandons the flush silently: no flush_done_o.
- Cycle numbering, request accepted in cycle 0, count 0, no further inc:
  - DRAIN in cycle 1.
  - Global: CLEAR in cycle 2, flush_done_o in cycle 3.
  - Selective: SWEEP in cycles 2..DEPTH+1, flush_done_o in cycle DEPTH+2.
- Drain latency extends by the number of cycles until the count reaches 0.
- All outputs are registered-state decodes except:
  - flush_ack_o, combinational from flush_req_i.
  - inv_valid_o, combinational from scan_tag_i.

## Structure
- mpt_pkg additions:
  - fwd_flush_state_e (IDLE, DRAIN, SWEEP, CLEAR, DONE).
  - FWD_INVALID_TAG constant: all-ones, MPTE_PTR_WIDTH bits.
- One sub-module: inflight_counter, a saturating up/down counter with parameter MAX and outputs count_o and zero_o.
- Everything else is FSM plus the scan counter in this module.

## Test plan
- Global flush, count 0: req/all=1 at cycle 0 → ack cycle 0, stall_o cycles 1-3, inv_all_o and victim_rst_o cycle 2, flush_done_o cycle 3, then IDLE.
- Selective flush, tag 0x100 present at entries 3 and 17 (DEPTH=32): inv_valid_o only at scan_idx 3 and 17; flush_done_o at cycle 34; victim_rst_o stays 0.
- Drain: count 2, req at cycle 0, inflight_inc_i also at cycle 0, decs at cycles 4, 6, 9 → DRAIN holds until cycle 9, CLEAR cycle 10, done cycle 11.
- Simultaneous inc & dec with count 1 during DRAIN → count stays 1 and DRAIN holds; lone dec next cycle → exit on the following cycle.
- Reset asserted during SWEEP at idx 10 → all outputs 0 immediately, no flush_done_o; a later request restarts scan at idx 0.
- Request held through a flush → not acked until IDLE; second flush starts the cycle after DONE; no inv_valid_o for non-matching tag 0xFFF.
